// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Owns the architectural PC and sequences instruction fetch from IM.
//   The held instruction retires on the decode handshake (instr_ready_i & ~stall_i).
//   On retire, npc_i is checked. A legal npc_i is loaded into the PC.
//   An illegal npc_i halts fetch and raises a sticky fault.
//
//   Build option: FETCH_TIMEOUT_EN
//     When defined, builds a WAIT-cycle counter.
//     After TIMEOUT_CYC WAIT cycles with no rvalid, the block faults with code 11.
//     When undefined, no counter is built and WAIT waits indefinitely.
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-high reset
//   pc_o           current PC (to next-PC logic)
//   npc_i          next PC for the held instruction
//   im_req_o       fetch request
//   im_addr_o      fetch address (= pc_o)
//   im_gnt_i       IM accepts the request this cycle
//   im_rvalid_i    im_rdata_i valid this cycle
//   im_rdata_i     fetched word
//   instr_o        held instruction
//   instr_valid_o  instr_o valid for decode
//   instr_ready_i  decode consumes instr_o
//   stall_i        hazard hold, blocks retire
//   retire_cnt_o   retired-instruction count (wraps)
//   fault_o        sticky fault, fetch halted
//   fault_code_o   01 misaligned npc, 10 npc out of range, 11 fetch timeout
//
// State | Meaning
// FETCH | request outstanding at pc, waiting for grant
// WAIT  | granted, waiting for read data
// HOLD  | instruction held for decode until retire
// HALT  | fault latched, fetch stopped until reset
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_6FFC,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] pc_o,
  input  logic [31:0] npc_i,
  output logic        im_req_o,
  output logic [31:0] im_addr_o,
  input  logic        im_gnt_i,
  input  logic        im_rvalid_i,
  input  logic [31:0] im_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        stall_i,
  output logic [31:0] retire_cnt_o,
  output logic        fault_o,
  output logic [1:0]  fault_code_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  // Keeps the request low until the first edge after reset release.
  logic        run_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        fault_q, fault_d;
  logic [1:0]  fault_code_q, fault_code_d;

  logic        retire;
  logic        npc_misaligned;
  logic        npc_out_of_range;

  assign retire           = instr_ready_i & ~stall_i;
  assign npc_misaligned   = (npc_i[1:0] != 2'b00);
  assign npc_out_of_range = (npc_i < PC_LO) || (npc_i > PC_HI);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             wait_expired;

  // Counter holds the number of WAIT cycles already completed.
  // The cycle that completes number TIMEOUT_CYC is the last chance for rvalid.
  assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) wait_cnt_q <= '0;
    else         wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      retire_cnt_q <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      retire_cnt_q <= retire_cnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    retire_cnt_d = retire_cnt_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      S_FETCH: begin
        // rvalid without a grant belongs to a request from before reset
        if (run_q && im_gnt_i) begin
          if (im_rvalid_i) begin
            instr_d = im_rdata_i;
            state_d = S_HOLD;
          end else begin
            state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
          end
        end
      end
      S_WAIT: begin
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
        if (im_rvalid_i) begin
          instr_d = im_rdata_i;
          state_d = S_HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_expired) begin
          fault_d      = 1'b1;
          fault_code_d = 2'b11;
          state_d      = S_HALT;
        end
`endif
      end
      S_HOLD: begin
        if (retire) begin
          retire_cnt_d = retire_cnt_q + 32'd1;
          if (npc_misaligned) begin
            fault_d      = 1'b1;
            fault_code_d = 2'b01;
            state_d      = S_HALT;
          end else if (npc_out_of_range) begin
            fault_d      = 1'b1;
            fault_code_d = 2'b10;
            state_d      = S_HALT;
          end else begin
            pc_d    = npc_i;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Outputs
  always_comb begin
    im_req_o      = 1'b0;
    instr_valid_o = 1'b0;
    case (state_q)
      S_FETCH: im_req_o      = run_q;
      S_HOLD:  instr_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign pc_o         = pc_q;
  assign im_addr_o    = pc_q;
  assign instr_o      = instr_q;
  assign retire_cnt_o = retire_cnt_q;
  assign fault_o      = fault_q;
  assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] LO     = 32'h0000_3000;
  localparam logic [31:0] HI     = 32'h0000_6FFC;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic [31:0] retire_cnt;
  logic        fault;
  logic [1:0]  fault_code;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  pc_fetch_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .pc_o          (pc),
    .npc_i         (npc),
    .im_req_o      (im_req),
    .im_addr_o     (im_addr),
    .im_gnt_i      (im_gnt),
    .im_rvalid_i   (im_rvalid),
    .im_rdata_i    (im_rdata),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .stall_i       (stall),
    .retire_cnt_o  (retire_cnt),
    .fault_o       (fault),
    .fault_code_o  (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          gdly;
    int          lat;
    int          hold;
    logic [31:0] npc;
    logic [31:0] word;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fault classification from the address rules alone.
  function automatic logic [1:0] ref_code(input logic [31:0] a);
    if ((a % 4) != 0) return 2'b01;
    if (a < LO || a > HI) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check_reset_vals();
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_req", im_req, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("req_before_edge", im_req, 0);
    step();
    chk("req_after_edge", im_req, 1);
    chk("addr_after_rst", im_addr, RST_PC);
    exp_pc  = RST_PC;
    exp_cnt = 0;
  endtask

  // One fetch/hold/retire transaction. Called with the DUT requesting.
  task automatic do_txn(input int gdly, input int lat, input int hold,
                        input logic [31:0] npc_v, input logic [31:0] word,
                        input logic [1:0] code);
    chk("req_start", im_req, 1);
    chk("addr_start", im_addr, exp_pc);
    chk("ivalid_fetch", instr_valid, 0);
    for (int i = 0; i < gdly; i++) begin
      im_gnt    = 1'b0;
      im_rvalid = 1'($urandom_range(0, 1));
      im_rdata  = $urandom;
      step();
      chk("req_no_gnt", im_req, 1);
      chk("ivalid_no_gnt", instr_valid, 0);
    end
    im_gnt    = 1'b1;
    im_rdata  = word;
    im_rvalid = (lat == 0);
    step();
    im_gnt    = 1'b0;
    im_rvalid = 1'b0;
    if (lat > 0) begin
      for (int i = 1; i < lat; i++) begin
        chk("req_wait", im_req, 0);
        chk("ivalid_wait", instr_valid, 0);
        chk("fault_wait", fault, 0);
        step();
      end
      chk("req_wait_last", im_req, 0);
      im_rvalid = 1'b1;
      im_rdata  = word;
      step();
      im_rvalid = 1'b0;
    end
    chk("ivalid_hold", instr_valid, 1);
    chk("instr_hold", instr, word);
    chk("req_hold", im_req, 0);
    for (int i = 0; i < hold; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        stall       = 1'b1;
        instr_ready = 1'($urandom_range(0, 1));
      end else begin
        stall       = 1'b0;
        instr_ready = 1'b0;
      end
      npc       = $urandom;
      im_gnt    = 1'($urandom_range(0, 1));
      im_rvalid = 1'($urandom_range(0, 1));
      im_rdata  = $urandom;
      step();
      chk("stall_pc", pc, exp_pc);
      chk("stall_ivalid", instr_valid, 1);
      chk("stall_instr", instr, word);
      chk("stall_cnt", retire_cnt, exp_cnt);
    end
    im_gnt      = 1'b0;
    im_rvalid   = 1'b0;
    stall       = 1'b0;
    instr_ready = 1'b1;
    npc         = npc_v;
    step();
    instr_ready = 1'b0;
    exp_cnt     = exp_cnt + 1;
    chk("retire_cnt", retire_cnt, exp_cnt);
    chk("ivalid_after", instr_valid, 0);
    if (code == 2'b00) begin
      exp_pc = npc_v;
      chk("pc_after", pc, exp_pc);
      chk("req_after", im_req, 1);
      chk("addr_after", im_addr, exp_pc);
      chk("no_fault", fault, 0);
    end else begin
      chk("fault_set", fault, 1);
      chk("fault_code", fault_code, code);
      chk("pc_kept", pc, exp_pc);
      chk("req_halt", im_req, 0);
      for (int i = 0; i < 2; i++) begin
        im_gnt      = 1'b1;
        im_rvalid   = 1'b1;
        instr_ready = 1'b1;
        npc         = LO;
        step();
        chk("halt_fault", fault, 1);
        chk("halt_code", fault_code, code);
        chk("halt_req", im_req, 0);
        chk("halt_ivalid", instr_valid, 0);
        chk("halt_pc", pc, exp_pc);
        chk("halt_cnt", retire_cnt, exp_cnt);
      end
      im_gnt      = 1'b0;
      im_rvalid   = 1'b0;
      instr_ready = 1'b0;
      do_reset();
    end
  endtask

  initial begin
    logic [31:0] nv;
    int          sel;

    reset       = 1'b1;
    npc         = '0;
    im_gnt      = 1'b0;
    im_rvalid   = 1'b0;
    im_rdata    = '0;
    instr_ready = 1'b0;
    stall       = 1'b0;
    exp_pc      = RST_PC;
    exp_cnt     = 0;

    //          gdly lat hold npc            word           code
    vecs[0]  = '{0, 0, 0, 32'h0000_3004, 32'h3C01_0001, 2'b00};
    vecs[1]  = '{0, 0, 3, 32'h0000_3010, 32'h1111_2222, 2'b00};
    vecs[2]  = '{1, 4, 2, 32'h0000_6FFC, 32'hA5A5_0F0F, 2'b00};
    vecs[3]  = '{2, 1, 0, 32'h0000_7000, 32'h0000_0013, 2'b10};
    vecs[4]  = '{0, 0, 1, 32'h0000_6FFC, 32'h0BAD_F00D, 2'b00};
    vecs[5]  = '{0, 2, 0, 32'h0000_3000, 32'h1234_5678, 2'b00};
    vecs[6]  = '{0, 0, 0, 32'h0000_3002, 32'hFFFF_FFFF, 2'b01};
    vecs[7]  = '{1, 0, 0, 32'h0000_2FFC, 32'h0000_0001, 2'b10};
    vecs[8]  = '{0, 0, 0, 32'h0000_7001, 32'h8000_0000, 2'b01};
    vecs[9]  = '{0, 3, 2, 32'h0000_3008, 32'h0F0F_F0F0, 2'b00};
`ifdef FETCH_TIMEOUT_EN
    vecs[10] = '{0, 16, 0, 32'h0000_3010, 32'hCAFE_0016, 2'b00};
`else
    vecs[10] = '{0, 40, 0, 32'h0000_3010, 32'hCAFE_0040, 2'b00};
`endif
    vecs[11] = '{3, 5, 3, 32'h0000_3014, 32'h7777_8888, 2'b00};

    #2;
    check_reset_vals();
    do_reset();

    for (int v = 0; v < 12; v++) begin
      do_txn(vecs[v].gdly, vecs[v].lat, vecs[v].hold, vecs[v].npc, vecs[v].word, vecs[v].code);
    end

    // Reset while a response is outstanding; the late rvalid must not surface.
    chk("pre_rst_pc", pc, 32'h0000_3014);
    im_gnt = 1'b1;
    step();
    im_gnt = 1'b0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("midwait_ivalid", instr_valid, 0);
    chk("midwait_pc", pc, RST_PC);
    chk("midwait_req", im_req, 0);
    chk("midwait_cnt", retire_cnt, 0);
    step();
    reset     = 1'b0;
    im_rvalid = 1'b1;
    im_rdata  = 32'hDEAD_BEEF;
    step();
    chk("late_rv_req", im_req, 1);
    chk("late_rv_ivalid", instr_valid, 0);
    step();
    chk("late_rv_ivalid2", instr_valid, 0);
    chk("late_rv_instr", instr, 32'h0);
    im_rvalid = 1'b0;
    exp_pc  = RST_PC;
    exp_cnt = 0;
    do_txn(0, 0, 0, 32'h0000_3020, 32'h2468_ACE0, 2'b00);

`ifdef FETCH_TIMEOUT_EN
    // Sixteen WAIT cycles with no data raise the timeout fault.
    im_gnt = 1'b1;
    step();
    im_gnt = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("to_no_fault", fault, 0);
    end
    step();
    chk("to_fault", fault, 1);
    chk("to_code", fault_code, 2'b11);
    chk("to_req", im_req, 0);
    chk("to_ivalid", instr_valid, 0);
    do_reset();
`endif

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        nv = LO + 32'(4 * $urandom_range(0, 4095));
      end else if (sel == 7) begin
        nv = $urandom;
        if (nv[1:0] == 2'b00) nv[0] = 1'b1;
      end else if (sel == 8) begin
        nv = HI + 32'(4 * $urandom_range(1, 100));
      end else begin
        nv = LO - 32'(4 * $urandom_range(1, 100));
      end
      do_txn($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3),
             nv, $urandom, ref_code(nv));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
